if_fetch_unit: RTL

- IF-stage fetch unit: owns the PCF register, issues instruction-memory requests over a valid/ready handshake, and fills the IF/ID pipeline register (PCD, InstrD, ValidD).
- Consumes PC_In from the next-PC selector and feeds PCF back to it.
- Handles variable-latency instruction memory, decode stalls, flushes and redirects while a fetch is in flight.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_id_reg.sv | 60 ++++++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the IF stage: fetch FSM encoding and architectural constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall freezes it, flush inserts a bubble, delivery loads a new word.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              deliver_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       instr_i,
    output logic [ADDR_W-1:0] pcd_o,
    output logic [31:0]       instrd_o,
    output logic              validd_o
);

    logic [ADDR_W-1:0] pcd_q, pcd_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;

    always_comb begin
        pcd_d   = pcd_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (stall_i) begin
            // A flush still kills the stalled instruction, but its fields stay put.
            if (flush_i) begin
                valid_d = 1'b0;
            end
        end else if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (deliver_i) begin
            pcd_d   = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcd_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pcd_q   <= pcd_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pcd_o    = pcd_q;
    assign instrd_o = instr_q;
    assign validd_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: owns PCF, runs the single-outstanding instruction-memory handshake
// and feeds the IF/ID register, surviving stalls, flushes and redirects mid-fetch.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic [ADDR_W-1:0] PC_In,
    input  logic              Redirect,
    input  logic              StallD,
    input  logic              FlushD,
    output logic              IReqValid,
    output logic [ADDR_W-1:0] IReqAddr,
    input  logic              IReqReady,
    input  logic              IRespValid,
    input  logic [31:0]       IRespData,
    output logic [ADDR_W-1:0] PCF,
    output logic [ADDR_W-1:0] PCD,
    output logic [31:0]       InstrD,
    output logic              ValidD,
    output logic              FetchBusy
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pcf_q, pcf_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic              hold_valid_q, hold_valid_d;

    logic              deliver;
    logic [ADDR_W-1:0] del_pc;
    logic [31:0]       del_instr;
    logic              ireq_valid;
    logic              fetch_busy;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        hold_instr_d = hold_instr_q;
        hold_valid_d = hold_valid_q;
        deliver      = 1'b0;
        del_pc       = pcf_q;
        del_instr    = IRespData;
        ireq_valid   = 1'b0;
        fetch_busy   = 1'b0;

        unique case (state_q)
            REQ: begin
                ireq_valid = 1'b1;
                fetch_busy = 1'b1;
                if (Redirect) begin
                    pcf_d = PC_In;
                end
                // An accepted request for the old PC must be drained before refetching.
                if (IReqReady) begin
                    state_d = Redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                fetch_busy = !IRespValid;
                if (Redirect) begin
                    pcf_d   = PC_In;
                    state_d = IRespValid ? REQ : DROP;
                end else if (IRespValid) begin
                    if (StallD) begin
                        hold_valid_d = 1'b1;
                        hold_instr_d = IRespData;
                        state_d      = HOLD;
                    end else begin
                        deliver = 1'b1;
                        pcf_d   = PC_In;
                        state_d = REQ;
                    end
                end
            end
            DROP: begin
                fetch_busy = 1'b1;
                if (Redirect) begin
                    pcf_d = PC_In;
                end
                if (IRespValid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                // PCF is frozen while holding, so it still names the buffered word.
                if (Redirect) begin
                    hold_valid_d = 1'b0;
                    pcf_d        = PC_In;
                    state_d      = REQ;
                end else if (!StallD) begin
                    deliver      = hold_valid_q;
                    del_instr    = hold_instr_q;
                    hold_valid_d = 1'b0;
                    pcf_d        = PC_In;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            state_q      <= REQ;
            pcf_q        <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk_i     (CPU_CLK),
        .rst_ni    (CPU_RST),
        .stall_i   (StallD),
        .flush_i   (FlushD),
        .deliver_i (deliver),
        .pc_i      (del_pc),
        .instr_i   (del_instr),
        .pcd_o     (PCD),
        .instrd_o  (InstrD),
        .validd_o  (ValidD)
    );

    assign IReqValid = ireq_valid;
    assign IReqAddr  = pcf_q;
    assign PCF       = pcf_q;
    assign FetchBusy = fetch_busy;

endmodule
